mem_phase_ctrl: RTL

- Sequences one load/run/dump job on the shared single-port program/data BRAM.
- Phases:
  - io_module receives words from UART into the BRAM.
  - The CPU core runs on the BRAM.
  - io_module sends results back over UART.
- Owns the BRAM port-A mux and drives io_module's ctrl_io_receive / ctrl_io_send.
- Sits between io_module, the CPU core and the bram instance on the clk_100 domain.

---
 rtl/mem_phase_pkg.sv | 53 +++++
 rtl/bram_port_mux.sv | 54 +++++
 rtl/mem_phase_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_phase_pkg.sv
// mem_phase_pkg
//   Shared types for the memory phase controller.
//   - state_t : job sequencer states (IDLE, LOAD, RUN_START, RUN, DUMP, DONE)
//   - grant_t : BRAM port-A owner (GNT_NONE, GNT_IO, GNT_CPU)
//   - helpers : state-to-grant decode, saturating counter increments
package mem_phase_pkg;

  localparam int LOAD_CNT_W = 16;
  localparam int TMO_CNT_W  = 20;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    RUN_START = 3'd2,
    RUN       = 3'd3,
    DUMP      = 3'd4,
    DONE      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IO   = 2'd1,
    GNT_CPU  = 2'd2
  } grant_t;

  // Which requester owns the BRAM port while the sequencer sits in a state.
  function automatic grant_t grant_of(input state_t st);
    grant_t g;
    case (st)
      LOAD, DUMP:     g = GNT_IO;
      RUN_START, RUN: g = GNT_CPU;
      IDLE, DONE:     g = GNT_NONE;
      default:        g = GNT_NONE;
    endcase
    return g;
  endfunction

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [LOAD_CNT_W-1:0] sat_inc_load(input logic [LOAD_CNT_W-1:0] v);
    logic [LOAD_CNT_W-1:0] r;
    if (v == {LOAD_CNT_W{1'b1}}) r = v;
    else                         r = v + LOAD_CNT_W'(1);
    return r;
  endfunction

  function automatic logic [TMO_CNT_W-1:0] sat_inc_tmo(input logic [TMO_CNT_W-1:0] v);
    logic [TMO_CNT_W-1:0] r;
    if (v == {TMO_CNT_W{1'b1}}) r = v;
    else                        r = v + TMO_CNT_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/bram_port_mux.sv
// bram_port_mux
//   Routes the granted requester onto BRAM port A with no added latency.
//   The non-granted requester's write is dropped; with no grant the port
//   is idle (we = 0, addr/din = 0).
//   Ports: grant; io_we/io_addr/io_wdata; cpu_we/cpu_addr/cpu_wdata;
//          bram_we/bram_addr/bram_din (to BRAM port A).
module bram_port_mux
  import mem_phase_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  grant_t            grant,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din
);

  // Grant-selected port drive; anything not granted is held at zero.
  always_comb begin
    bram_we   = 1'b0;
    bram_addr = {ADDR_W{1'b0}};
    bram_din  = {DATA_W{1'b0}};
    case (grant)
      GNT_IO: begin
        bram_we   = io_we;
        bram_addr = io_addr;
        bram_din  = io_wdata;
      end
      GNT_CPU: begin
        bram_we   = cpu_we;
        bram_addr = cpu_addr;
        bram_din  = cpu_wdata;
      end
      GNT_NONE: begin
        bram_we   = 1'b0;
        bram_addr = {ADDR_W{1'b0}};
        bram_din  = {DATA_W{1'b0}};
      end
      default: begin
        bram_we   = 1'b0;
        bram_addr = {ADDR_W{1'b0}};
        bram_din  = {DATA_W{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/mem_phase_ctrl.sv
// mem_phase_ctrl
//   Sequences one load / run / dump job on the shared program/data BRAM:
//   io_module fills the BRAM, the CPU runs on it, io_module sends results.
//   Inputs : clk_100, rst (sync, active high), start, io_we/io_addr/io_wdata,
//            io_send_done, cpu_we/cpu_addr/cpu_wdata, cpu_done, bram_dout.
//   Outputs: bram_we/bram_addr/bram_din (port-A mux), rd_data,
//            ctrl_io_receive, ctrl_io_send, cpu_start, busy, done,
//            err_timeout (sticky), err_violation.
//   Build option: define MEM_PHASE_VIOLATION_EN to flag writes from the
//   requester that does not currently own the BRAM (err_violation);
//   otherwise err_violation is tied low. Writes are suppressed either way.
module mem_phase_ctrl
  import mem_phase_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int LOAD_LEN     = 4,
  parameter int IDLE_TIMEOUT = 1000000
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              start,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  input  logic              io_send_done,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_done,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic [DATA_W-1:0] rd_data,
  output logic              ctrl_io_receive,
  output logic              ctrl_io_send,
  output logic              cpu_start,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_violation
);

  localparam logic [LOAD_CNT_W-1:0] LOAD_LAST = LOAD_CNT_W'(LOAD_LEN - 1);
  localparam logic [TMO_CNT_W-1:0]  TMO_LAST  = TMO_CNT_W'(IDLE_TIMEOUT - 1);

  state_t                state_r, state_s;
  grant_t                grant_r;
  logic [LOAD_CNT_W-1:0] load_cnt_r, load_cnt_s;
  logic [TMO_CNT_W-1:0]  tmo_cnt_r, tmo_cnt_s;
  logic                  err_timeout_r, err_timeout_s;
  logic                  start_acc_s;
  logic                  ctrl_io_receive_r, ctrl_io_send_r, cpu_start_r, busy_r, done_r;

  // Next-state, load/timeout counters and timeout flag.
  always_comb begin
    state_s       = state_r;
    load_cnt_s    = load_cnt_r;
    tmo_cnt_s     = tmo_cnt_r;
    err_timeout_s = err_timeout_r;
    start_acc_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s       = LOAD;
          load_cnt_s    = {LOAD_CNT_W{1'b0}};
          tmo_cnt_s     = {TMO_CNT_W{1'b0}};
          err_timeout_s = 1'b0;
          start_acc_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        // A write always beats timeout expiry in the same cycle.
        if (io_we) begin
          load_cnt_s = sat_inc_load(load_cnt_r);
          tmo_cnt_s  = {TMO_CNT_W{1'b0}};
          if (load_cnt_r == LOAD_LAST) state_s = RUN_START;
          else                         state_s = LOAD;
        end else begin
          tmo_cnt_s = sat_inc_tmo(tmo_cnt_r);
          if (tmo_cnt_r == TMO_LAST) begin
            err_timeout_s = 1'b1;
            state_s       = IDLE;
          end else begin
            state_s = LOAD;
          end
        end
      end
      RUN_START: state_s = RUN;
      RUN: begin
        if (cpu_done) state_s = DUMP;
        else          state_s = RUN;
      end
      DUMP: begin
        if (io_send_done) state_s = DONE;
        else              state_s = DUMP;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, counters and all control outputs; outputs decode the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_r           <= IDLE;
      grant_r           <= GNT_NONE;
      load_cnt_r        <= {LOAD_CNT_W{1'b0}};
      tmo_cnt_r         <= {TMO_CNT_W{1'b0}};
      err_timeout_r     <= 1'b0;
      ctrl_io_receive_r <= 1'b0;
      ctrl_io_send_r    <= 1'b0;
      cpu_start_r       <= 1'b0;
      busy_r            <= 1'b0;
      done_r            <= 1'b0;
    end else begin
      state_r           <= state_s;
      grant_r           <= grant_of(state_s);
      load_cnt_r        <= load_cnt_s;
      tmo_cnt_r         <= tmo_cnt_s;
      err_timeout_r     <= err_timeout_s;
      ctrl_io_receive_r <= (state_s == LOAD);
      ctrl_io_send_r    <= (state_s == DUMP);
      cpu_start_r       <= (state_s == RUN_START);
      busy_r            <= (state_s != IDLE);
      done_r            <= (state_s == DONE);
    end
  end

`ifdef MEM_PHASE_VIOLATION_EN
  logic viol_s;
  logic err_violation_r;

  assign viol_s = (cpu_we && (grant_r != GNT_CPU)) || (io_we && (grant_r != GNT_IO));

  // Sticky violation flag, re-armed by an accepted start.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      err_violation_r <= 1'b0;
    end else if (start_acc_s) begin
      err_violation_r <= viol_s;
    end else if (viol_s) begin
      err_violation_r <= 1'b1;
    end else begin
      err_violation_r <= err_violation_r;
    end
  end

  assign err_violation = err_violation_r;
`else
  assign err_violation = 1'b0;
`endif

  bram_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .grant     (grant_r),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din)
  );

  assign rd_data         = bram_dout;
  assign ctrl_io_receive = ctrl_io_receive_r;
  assign ctrl_io_send    = ctrl_io_send_r;
  assign cpu_start       = cpu_start_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign err_timeout     = err_timeout_r;

endmodule
